// File: rtl/ja_rx_pkg.sv
// Shared types and width helpers for the PMOD JA serial receiver.
// Optional parity framing is selected in the top by JA_RX_PARITY_EN.
package ja_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } rx_state_e;

  localparam int DATA_W_DFLT  = 32;
  localparam int TIMEOUT_DFLT = 4096;

  // Bit count must represent 0 .. frame_bits+1 (the +1 flags an over-long frame).
  function automatic int cnt_w(input int frame_bits);
    return $clog2(frame_bits + 2);
  endfunction

  function automatic int to_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

  localparam int CNT_W = cnt_w(DATA_W_DFLT);
  localparam int TO_W  = to_w(TIMEOUT_DFLT);

endpackage

// File: rtl/ja_serial_rx_if.sv
// Single-entry valid/ready word stream from the JA receiver to the MMIO path.
interface ja_serial_rx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ja_rx_sync.sv
// Multi-flop synchronizer with a configurable reset level and edge pulses
// derived from the last stage against a registered copy.
module ja_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  =  level & ~prev_q;
  assign fall  = ~level &  prev_q;

endmodule

// File: rtl/ja_serial_rx.sv
// PMOD JA receive end: synchronizes the 3-wire link, deserializes MSB-first frames
// into a one-word buffer and reports busy back to the sender. Macro: JA_RX_PARITY_EN.
module ja_serial_rx
  import ja_rx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ja_sdata,
  input  logic           ja_sclk,
  input  logic           ja_frame_n,
  output logic           ja_busy,
  ja_serial_rx_if.master rx,
  output logic           rx_overflow,
  output logic           rx_error,
  input  logic           clear_err
);

`ifdef JA_RX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int FCNT_W = cnt_w(FRAME_W);
  localparam int FTO_W  = to_w(TIMEOUT_CYC);

  localparam logic [FCNT_W-1:0] CNT_FULL = FCNT_W'(FRAME_W);
  localparam logic [FCNT_W-1:0] CNT_SAT  = FCNT_W'(FRAME_W + 1);
  localparam logic [FTO_W-1:0]  TO_LAST  = FTO_W'(TIMEOUT_CYC - 1);

  logic sdata_lvl, sdata_rise_unused, sdata_fall_unused;
  logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
  logic frame_rise, frame_fall, frame_lvl_unused;

  ja_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
    .clock (clock),
    .reset (reset),
    .din   (ja_sdata),
    .level (sdata_lvl),
    .rise  (sdata_rise_unused),
    .fall  (sdata_fall_unused)
  );

  ja_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clock (clock),
    .reset (reset),
    .din   (ja_sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  // frame_n resets to the asserted level so a frame already running at
  // reset release never produces the falling edge needed to start capture.
  ja_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_frame (
    .clock (clock),
    .reset (reset),
    .din   (ja_frame_n),
    .level (frame_lvl_unused),
    .rise  (frame_rise),
    .fall  (frame_fall)
  );

  rx_state_e           state_q;
  logic [FRAME_W-1:0]  shift_q;
  logic [FCNT_W-1:0]   bit_cnt_q;
  logic [FTO_W-1:0]    to_cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                busy_q;
  logic                ovf_q;
  logic                err_q;

  logic [DATA_W-1:0]   payload;
  logic                par_bad;
  logic                pop;
  logic                load;
  logic                err_set;
  logic                ovf_set;
  logic                timeout_hit;
  logic                valid_nxt;

`ifdef JA_RX_PARITY_EN
  assign payload = shift_q[DATA_W:1];
  assign par_bad = ^shift_q;
`else
  assign payload = shift_q;
  assign par_bad = 1'b0;
`endif

  assign pop = valid_q & rx.rx_ready;

  always_comb begin
    timeout_hit = 1'b0;
    err_set     = 1'b0;
    ovf_set     = 1'b0;
    load        = 1'b0;
    if (state_q == SHIFT && !sclk_rise && !frame_rise && to_cnt_q == TO_LAST) begin
      timeout_hit = 1'b1;
      err_set     = 1'b1;
    end
    if (state_q == COMMIT) begin
      if (bit_cnt_q != CNT_FULL || par_bad) begin
        err_set = 1'b1;
      end else if (!valid_q || pop) begin
        load = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
    valid_nxt = load | (valid_q & ~pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_fall) begin
            state_q   <= SHIFT;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
          end
        end
        SHIFT: begin
          // A bit arriving with the closing frame edge is still captured.
          if (sclk_rise) begin
            shift_q   <= {shift_q[FRAME_W-2:0], sdata_lvl};
            bit_cnt_q <= (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + FCNT_W'(1);
            to_cnt_q  <= '0;
          end else begin
            to_cnt_q  <= to_cnt_q + FTO_W'(1);
          end
          if (frame_rise) begin
            state_q <= COMMIT;
          end else if (timeout_hit) begin
            state_q <= IDLE;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q <= payload;
      end
      valid_q <= valid_nxt;
      busy_q  <= valid_nxt;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clear_err) begin
        ovf_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (clear_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign ja_busy     = busy_q;
  assign rx_overflow = ovf_q;
  assign rx_error    = err_q;

endmodule
